track_renderer: RTL and testbench
=================================

# track_renderer

Reads the four 480-bit lane bitmaps produced by the game controller, along with the live key states, and turns them into a 640x480@60 VGA picture of the 4K playfield. Bit y of a track word is screen row y: row 0 is the top, and notes enter at low rows and fall toward higher rows. The block generates its own VGA timing. It latches all four tracks once per frame so that notes never tear mid-frame, and it draws the lanes, the notes, the judgement line and the pressed-key highlights.

## Interface
- CLK_DIV, 4: clk cycles per pixel (100 MHz → 25 MHz); legal range 1..15.
- LANE_X0, 160: x of the left edge of lane 0.
- LANE_W, 80: lane width in pixels; lane i spans [LANE_X0+i·LANE_W, LANE_X0+(i+1)·LANE_W-1].
- JUDGE_ROW, 445: screen row of the judgement line; matches the controller's judge bit.
- clk, input, 1: single system clock.
- rst, input, 1: reset, asynchronous, active-low.
- track0..track3, input, 480 each: lane bitmaps; bit y = row y.
- key0..key3, input, 1 each: key held, active-high.
- vga_r, vga_g, vga_b, output, 4 each: pixel colour.
- hsync, vsync, output, 1 each: sync pulses, active-low.
- frame_start, output, 1: one-clk pulse issued when the track snapshot is taken.

## Operation
- **Pixel enable:** divider counter 0..CLK_DIV-1. pix_en is asserted for one clk when the counter equals CLK_DIV-1. With CLK_DIV=1, pix_en is constantly high.
- **Timing counters:** updated only on pix_en.
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps 524→0.
- **Sync and visible area:**
  - Horizontal: visible 0..639; hsync low for 656..751.
  - Vertical: visible 0..479; vsync low for 490..491.
- **Snapshot:** on the pix_en where h_cnt=799 and v_cnt=479 (the last pixel before vertical blanking), all four track inputs are copied into internal snap0..snap3. frame_start pulses in the same clk.
  - Track changes at any other time are not visible until the next snapshot.
- **Pixel colour:** evaluated from the current (h_cnt, v_cnt) and snap. First matching rule wins:
  1. Outside the visible area → 000.
  2. x outside all lanes → 000.
  3. v_cnt = JUDGE_ROW → FFF (white).
  4. snap_i[v_cnt] = 1 → lane colour: lane0 F00, lane1 0F0, lane2 00F, lane3 FF0.
  5. key_i = 1 → dim colour: lane0 400, lane1 040, lane2 004, lane3 440.
  6. x = first or last column of the lane → 444 (border).
  7. Otherwise → 000.
- **Lane index:** (x − LANE_X0) / LANE_W. Implement as a compare chain against the precomputed boundaries, not a divider.
- **Key sampling:** keys are sampled live at the output-register update. They are not latched at the snapshot.
- **Reset (asynchronous assertion):** all of the following take effect immediately, independent of clk:
  - divider, h_cnt and v_cnt = 0;
  - snap0..snap3 = 0;
  - vga_r, vga_g, vga_b = 0;
  - hsync = vsync = 1;
  - frame_start = 0.
  On release, counting restarts from (0,0).

## Timing
- **Outputs:** colour, hsync and vsync are all registered on pix_en from the same (h_cnt, v_cnt). This gives one pixel period of latency, with all three mutually aligned.
- **Snapshot update:** the snapshot registers update on the same pix_en edge as the counters. Row 0 of the next frame already uses the new snapshot.
- **frame_start:** registered and high for exactly 1 clk, coincident with the snap update edge.
- **Frame length:** 800×525×CLK_DIV clk cycles, i.e. 1,680,000 at the default CLK_DIV.
- **Simultaneous events:**
  - Snapshot and output update on the same pix_en: the output for (799,479) is blank, so there is no conflict.
  - Reset concurrent with the snapshot: reset wins.

## Test plan
- **Sync timing:** CLK_DIV=4, release reset, measure.
  - hsync low for 96 px (384 clk), with a period of 3200 clk.
  - vsync low for 2 lines (6400 clk), with a period of 1,680,000 clk.
  - frame_start once per frame.
- **Note draw:** set track1 bit 200 = 1 and all else 0 before the snapshot.
  - Frame 2, row 200, x 240..319 → 0F0, except the border columns, which show the note colour (the note rule has higher priority).
  - x 239 and x 320 → not green.
- **Tear-free:** set track0[100]=1 mid-frame (v_cnt=50).
  - The current frame shows row 100 of lane 0 as black.
  - The next frame shows F00.
- **Priority:** track2[445]=1 with key2=1 → row 445 in lane 2 is FFF. Row 444 with key2=1 and no note → 004.
- **Blanking:** all tracks all-ones → every pixel with x≥640 or y≥480, and any x outside 160..479, is 000.
- **Reset mid-line:** assert rst at h_cnt=300, v_cnt=100.
  - Outputs immediately 0/0/0 with hsync=vsync=1.
  - After release, the first hsync falling edge comes 656 pixels later.

Source files
------------

// File: rtl/track_renderer.sv
// 4K playfield VGA renderer: free-running 640x480@60 timing, per-frame lane snapshot,
// and a priority colour mux registered on the pixel enable.
module track_renderer #(
   parameter int CLK_DIV    = 4,
   parameter int LANE_X0    = 160,
   parameter int LANE_W     = 80,
   parameter int JUDGE_ROW  = 445,
   parameter int H_VIS      = 640,
   parameter int H_SYNC_BEG = 656,
   parameter int H_SYNC_END = 752,
   parameter int H_TOTAL    = 800,
   parameter int V_VIS      = 480,
   parameter int V_SYNC_BEG = 490,
   parameter int V_SYNC_END = 492,
   parameter int V_TOTAL    = 525
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [479:0] track0,
   input  logic [479:0] track1,
   input  logic [479:0] track2,
   input  logic [479:0] track3,
   input  logic         key0,
   input  logic         key1,
   input  logic         key2,
   input  logic         key3,
   output logic [3:0]   vga_r,
   output logic [3:0]   vga_g,
   output logic [3:0]   vga_b,
   output logic         hsync,
   output logic         vsync,
   output logic         frame_start
);

   localparam logic [47:0] NOTE_COLS = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
   localparam logic [47:0] DIM_COLS  = {12'h440, 12'h004, 12'h040, 12'h400};

   logic [3:0]        div_reg;
   logic              pix_en;
   logic [9:0]        h_cnt_reg;
   logic [9:0]        v_cnt_reg;
   logic              h_last;
   logic              v_last;
   logic              snap_take;
   logic [3:0][479:0] snap_reg;
   logic [3:0]        key_vec;
   logic [3:0]        in_lane;
   logic [3:0]        edge_col;
   logic [3:0]        note_hit;
   logic [3:0][11:0]  lane_rgb;
   logic [8:0]        row_idx;
   logic              visible;
   logic              judge_row;
   logic [11:0]       rgb_next;
   logic [11:0]       rgb_reg;
   logic              hsync_next;
   logic              vsync_next;
   logic              hsync_reg;
   logic              vsync_reg;
   logic              frame_start_reg;

   assign pix_en    = (div_reg == 4'(CLK_DIV - 1));
   assign h_last    = (h_cnt_reg == 10'(H_TOTAL - 1));
   assign v_last    = (v_cnt_reg == 10'(V_TOTAL - 1));
   // Last pixel before vertical blanking: the whole next frame sees one consistent snapshot.
   assign snap_take = pix_en && h_last && (v_cnt_reg == 10'(V_VIS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_reg   <= '0;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         div_reg <= pix_en ? 4'd0 : div_reg + 4'd1;
         if (pix_en) begin
            h_cnt_reg <= h_last ? 10'd0 : h_cnt_reg + 10'd1;
            if (h_last) begin
               v_cnt_reg <= v_last ? 10'd0 : v_cnt_reg + 10'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_reg        <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= snap_take;
         if (snap_take) begin
            snap_reg <= {track3, track2, track1, track0};
         end
      end
   end

   assign key_vec   = {key3, key2, key1, key0};
   assign row_idx   = v_cnt_reg[8:0];
   assign visible   = (h_cnt_reg < 10'(H_VIS)) && (v_cnt_reg < 10'(V_VIS));
   assign judge_row = (v_cnt_reg == 10'(JUDGE_ROW));

   // Lane boundaries are elaboration-time constants, so lane decode is a set of compares.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int LO = LANE_X0 + gi * LANE_W;
      localparam int HI = LO + LANE_W - 1;
      assign in_lane[gi]  = (h_cnt_reg >= 10'(LO)) && (h_cnt_reg <= 10'(HI));
      assign edge_col[gi] = (h_cnt_reg == 10'(LO)) || (h_cnt_reg == 10'(HI));
      assign note_hit[gi] = snap_reg[gi][row_idx];
      assign lane_rgb[gi] = note_hit[gi] ? NOTE_COLS[gi*12 +: 12] :
                            key_vec[gi]  ? DIM_COLS[gi*12 +: 12]  :
                            edge_col[gi] ? 12'h444 : 12'h000;
   end

   always_comb begin
      rgb_next = 12'h000;
      if (visible) begin
         for (int i = 0; i < 4; i++) begin
            if (in_lane[i]) begin
               rgb_next = judge_row ? 12'hFFF : lane_rgb[i];
            end
         end
      end
   end

   assign hsync_next = !((h_cnt_reg >= 10'(H_SYNC_BEG)) && (h_cnt_reg < 10'(H_SYNC_END)));
   assign vsync_next = !((v_cnt_reg >= 10'(V_SYNC_BEG)) && (v_cnt_reg < 10'(V_SYNC_END)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_reg   <= 12'h000;
         hsync_reg <= 1'b1;
         vsync_reg <= 1'b1;
      end else if (pix_en) begin
         rgb_reg   <= rgb_next;
         hsync_reg <= hsync_next;
         vsync_reg <= vsync_next;
      end
   end

   assign vga_r       = rgb_reg[11:8];
   assign vga_g       = rgb_reg[7:4];
   assign vga_b       = rgb_reg[3:0];
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_track_renderer.sv
// Bench for track_renderer: a full-size instance for line timing and reset, and a
// reduced-geometry instance so that snapshot and multi-frame behaviour fit a short run.
`timescale 1ns/1ps
module tb_track_renderer;

   localparam int HT = 72;
   localparam int FR = HT * 45;

   typedef struct {
      int          f;
      int          x;
      int          y;
      logic [3:0]  keys;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_f;
   logic         rst_s;
   logic [479:0] t0, t1, t2, t3;
   logic [3:0]   keys;
   logic [3:0]   r_f, g_f, b_f, r_s, g_s, b_s;
   logic         hs_f, vs_f, fs_f, hs_s, vs_s, fs_s;
   int           cyc_f, cyc_s;
   int           checks = 0;
   int           failures = 0;
   int           fs_cnt = 0;
   int           fs_first = 0;
   int           fs_second = 0;
   vec_t         tbl [35];

   always #5 clk = ~clk;

   track_renderer u_full (
      .clk(clk), .rst(rst_f),
      .track0(t0), .track1(t1), .track2(t2), .track3(t3),
      .key0(keys[0]), .key1(keys[1]), .key2(keys[2]), .key3(keys[3]),
      .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
      .hsync(hs_f), .vsync(vs_f), .frame_start(fs_f)
   );

   track_renderer #(
      .CLK_DIV(1), .LANE_X0(16), .LANE_W(8), .JUDGE_ROW(30),
      .H_VIS(64), .H_SYNC_BEG(66), .H_SYNC_END(70), .H_TOTAL(72),
      .V_VIS(40), .V_SYNC_BEG(42), .V_SYNC_END(44), .V_TOTAL(45)
   ) u_small (
      .clk(clk), .rst(rst_s),
      .track0(t0), .track1(t1), .track2(t2), .track3(t3),
      .key0(keys[0]), .key1(keys[1]), .key2(keys[2]), .key3(keys[3]),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
      .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
   );

   always @(posedge clk or negedge rst_f) begin
      if (!rst_f) cyc_f <= 0;
      else        cyc_f <= cyc_f + 1;
   end

   always @(posedge clk or negedge rst_s) begin
      if (!rst_s) cyc_s <= 0;
      else        cyc_s <= cyc_s + 1;
   end

   always @(negedge clk) begin
      if (rst_s && fs_s) begin
         fs_cnt <= fs_cnt + 1;
         if (fs_cnt == 0)      fs_first  <= cyc_s;
         else if (fs_cnt == 1) fs_second <= cyc_s;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic wait_f(input int c);
      int guard = 0;
      while (cyc_f < c && guard < 40000) begin @(negedge clk); guard++; end
      if (cyc_f < c) begin
         checks++; failures++;
         $display("FAIL wait_full actual=%0d expected=%0d", cyc_f, c);
      end
   endtask

   task automatic wait_s(input int c);
      int guard = 0;
      while (cyc_s < c && guard < 40000) begin @(negedge clk); guard++; end
      if (cyc_s < c) begin
         checks++; failures++;
         $display("FAIL wait_small actual=%0d expected=%0d", cyc_s, c);
      end
   endtask

   // Full instance: pixel n is registered at clk 4*(n+1) after reset release.
   task automatic run_f(input string name, input int n, input logic [3:0] k, input logic [11:0] exp);
      wait_f(4 * (n + 1) - 1);
      keys = k;
      @(negedge clk);
      chk(name, 32'({r_f, g_f, b_f}), 32'(exp));
   endtask

   task automatic edge_f(input string name, input logic lvl, input int exp);
      int guard = 0;
      while (hs_f !== lvl && guard < 10000) begin @(negedge clk); guard++; end
      chk(name, 32'(cyc_f), 32'(exp));
   endtask

   // Small instance: pixel n is registered at clk n+1 after reset release.
   task automatic run_s(input string name, input vec_t v);
      int n;
      n = v.f * FR + v.y * HT + v.x;
      wait_s(n);
      keys = v.keys;
      @(negedge clk);
      chk({name, "_rgb"}, 32'({r_s, g_s, b_s}), 32'(v.rgb));
      chk({name, "_hs"}, 32'(hs_s), 32'(v.hs));
      chk({name, "_vs"}, 32'(vs_s), 32'(v.vs));
   endtask

   function automatic vec_t mk(int f, int x, int y, logic [3:0] k, logic [11:0] rgb,
                               logic hs, logic vs);
      vec_t v;
      v.f = f; v.x = x; v.y = y; v.keys = k; v.rgb = rgb; v.hs = hs; v.vs = vs;
      return v;
   endfunction

   initial begin
      // frame 0: snapshot still empty
      tbl[0]  = mk(0, 10,  0, 4'b0000, 12'h000, 1, 1);
      tbl[1]  = mk(0, 16,  0, 4'b0000, 12'h444, 1, 1);
      tbl[2]  = mk(0, 23,  0, 4'b0000, 12'h444, 1, 1);
      tbl[3]  = mk(0, 26,  5, 4'b0010, 12'h040, 1, 1);
      tbl[4]  = mk(0, 34,  5, 4'b0100, 12'h004, 1, 1);
      tbl[5]  = mk(0, 65,  5, 4'b0000, 12'h000, 1, 1);
      tbl[6]  = mk(0, 66,  5, 4'b0000, 12'h000, 0, 1);
      tbl[7]  = mk(0, 69,  5, 4'b0000, 12'h000, 0, 1);
      tbl[8]  = mk(0, 70,  5, 4'b0000, 12'h000, 1, 1);
      tbl[9]  = mk(0, 45, 10, 4'b1000, 12'h440, 1, 1);
      tbl[10] = mk(0, 47, 10, 4'b0000, 12'h444, 1, 1);
      tbl[11] = mk(0, 48, 10, 4'b1000, 12'h000, 1, 1);
      tbl[12] = mk(0, 26, 20, 4'b0000, 12'h000, 1, 1);
      tbl[13] = mk(0, 10, 30, 4'b0000, 12'h000, 1, 1);
      tbl[14] = mk(0, 30, 30, 4'b0000, 12'hFFF, 1, 1);
      tbl[15] = mk(0, 20, 41, 4'b0000, 12'h000, 1, 1);
      tbl[16] = mk(0, 20, 42, 4'b0000, 12'h000, 1, 0);
      tbl[17] = mk(0, 20, 43, 4'b0000, 12'h000, 1, 0);
      tbl[18] = mk(0, 20, 44, 4'b0000, 12'h000, 1, 1);
      // frame 1: track0 all ones, track1[20], track2[30]
      tbl[19] = mk(1, 15,  2, 4'b0000, 12'h000, 1, 1);
      tbl[20] = mk(1, 16,  2, 4'b0000, 12'hF00, 1, 1);
      tbl[21] = mk(1, 18,  2, 4'b0000, 12'hF00, 1, 1);
      tbl[22] = mk(1, 48,  2, 4'b0000, 12'h000, 1, 1);
      tbl[23] = mk(1, 18,  3, 4'b0001, 12'hF00, 1, 1);
      tbl[24] = mk(1, 23, 20, 4'b0000, 12'hF00, 1, 1);
      tbl[25] = mk(1, 24, 20, 4'b0000, 12'h0F0, 1, 1);
      tbl[26] = mk(1, 28, 20, 4'b0000, 12'h0F0, 1, 1);
      tbl[27] = mk(1, 31, 20, 4'b0000, 12'h0F0, 1, 1);
      tbl[28] = mk(1, 32, 20, 4'b0000, 12'h444, 1, 1);
      tbl[29] = mk(1, 26, 21, 4'b0000, 12'h000, 1, 1);
      tbl[30] = mk(1, 34, 29, 4'b0100, 12'h004, 1, 1);
      tbl[31] = mk(1, 20, 30, 4'b0000, 12'hFFF, 1, 1);
      tbl[32] = mk(1, 34, 30, 4'b0100, 12'hFFF, 1, 1);
      tbl[33] = mk(1, 67, 30, 4'b0000, 12'h000, 0, 1);
      tbl[34] = mk(1, 20, 41, 4'b0000, 12'h000, 1, 1);

      rst_f = 1'b0;
      rst_s = 1'b0;
      keys  = 4'b0000;
      t0 = '0; t1 = '0; t2 = '0; t3 = '0;
      repeat (5) @(negedge clk);
      chk("rst_full_rgb", 32'({r_f, g_f, b_f}), 32'h0);
      chk("rst_full_sync", 32'({hs_f, vs_f, fs_f}), 32'b110);
      chk("rst_small_rgb", 32'({r_s, g_s, b_s}), 32'h0);
      chk("rst_small_sync", 32'({hs_s, vs_s, fs_s}), 32'b110);

      // ---- full-size timing, CLK_DIV=4 ----
      rst_f = 1'b1;
      run_f("full_border_x160", 160, 4'b0000, 12'h444);
      run_f("full_key0_x200", 200, 4'b0001, 12'h400);
      run_f("full_outside_x600", 600, 4'b0001, 12'h000);
      keys = 4'b0000;
      edge_f("hsync_first_fall", 1'b0, 4 * 657);
      edge_f("hsync_rise", 1'b1, 4 * 753);
      edge_f("hsync_second_fall", 1'b0, 4 * 1457);
      chk("vsync_line1_high", 32'(vs_f), 32'h1);

      // reset while internal h_cnt=300 on line 2, output showing lane 1 with key1 held
      keys = 4'b0010;
      wait_f(4 * 1900 + 1);
      chk("pre_reset_rgb", 32'({r_f, g_f, b_f}), 32'h040);
      rst_f = 1'b0;
      #1;
      chk("async_reset_rgb", 32'({r_f, g_f, b_f}), 32'h0);
      chk("async_reset_sync", 32'({hs_f, vs_f, fs_f}), 32'b110);
      keys = 4'b0000;
      repeat (3) @(negedge clk);
      rst_f = 1'b1;
      edge_f("hsync_fall_after_reset", 1'b0, 4 * 657);
      rst_f = 1'b0;

      // ---- reduced geometry, CLK_DIV=1 ----
      t0 = '1;
      t1[20] = 1'b1;
      t2[30] = 1'b1;
      @(negedge clk);
      rst_s = 1'b1;
      for (int i = 0; i < 35; i++) begin
         run_s($sformatf("vec%0d_f%0d_x%0d_y%0d", i, tbl[i].f, tbl[i].x, tbl[i].y), tbl[i]);
      end

      // tear-free: tracks change mid frame 2, visible only from frame 3
      wait_s(2 * FR + 5 * HT);
      t0 = '0;
      t3[25] = 1'b1;
      run_s("tear_f2_lane0", mk(2, 18, 10, 4'b0000, 12'hF00, 1, 1));
      run_s("tear_f2_lane3", mk(2, 42, 25, 4'b0000, 12'h000, 1, 1));
      run_s("tear_f3_lane0", mk(3, 18, 10, 4'b0000, 12'h000, 1, 1));
      run_s("tear_f3_lane3", mk(3, 42, 25, 4'b0000, 12'hFF0, 1, 1));

      chk("frame_start_first", 32'(fs_first), 32'(39 * HT + 72));
      chk("frame_start_second", 32'(fs_second), 32'(FR + 39 * HT + 72));
      chk("frame_start_count", 32'(fs_cnt), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
